// File: rtl/uart_rx_ext.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_rx_ext: 16x-oversampled UART receiver, runtime divisor and parity,
// 3-sample majority vote, valid/ready output register with status flags.
// Rev 1.0
// -----------------------------------------------------------------------------
module uart_rx_ext #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR_BIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic [1:0]          par_mode,
  input  logic                rx,
  output logic [DBIT-1:0]     r_data,
  output logic                r_valid,
  input  logic                r_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det,
  output logic                overrun,
  output logic                busy
);

  localparam int c_NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic                meta_q, rx_s_q;
  logic [DVSR_BIT-1:0] cnt_q, cnt_d, dvsr_l_q, dvsr_l_d;
  logic [1:0]          par_l_q, par_l_d;
  logic                armed_q, armed_d;
  logic [4:0]          s_q, s_d;
  logic [c_NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]     sh_q, sh_d;
  logic                s7_q, s7_d, s8_q, s8_d;
  logic                pbit_q, pbit_d, pe_q, pe_d, fe_q, fe_d;
  logic [DBIT-1:0]     data_q, data_d;
  logic                valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                brk_q, brk_d, ovr_q, ovr_d;

  logic w_tick, w_vote, w_start, w_par_en, w_done, w_brk;

  assign w_tick   = (cnt_q == dvsr_l_q);
  assign w_vote   = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
  assign w_start  = (state_q == IDLE) && armed_q && !rx_s_q;
  assign w_par_en = (par_l_q == 2'b01) || (par_l_q == 2'b10);
  assign w_done   = (state_q == STOP) && w_tick && (s_q == 5'(SB_TICK - 1));
  assign w_brk    = fe_q && (sh_q == '0) && (!w_par_en || !pbit_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = w_tick ? '0 : cnt_q + 1'b1;
    dvsr_l_d = dvsr_l_q;
    par_l_d  = par_l_q;
    armed_d  = armed_q;
    s_d      = s_q;
    n_d      = n_q;
    sh_d     = sh_q;
    s7_d     = s7_q;
    s8_d     = s8_q;
    pbit_d   = pbit_q;
    pe_d     = pe_q;
    fe_d     = fe_q;

    if ((state_q == IDLE) && rx_s_q) armed_d = 1'b1;
    if ((state_q != IDLE) && w_tick) begin
      s_d = s_q + 5'd1;
      if (s_q == 5'd7) s7_d = rx_s_q;
      if (s_q == 5'd8) s8_d = rx_s_q;
    end

    case (state_q)
      IDLE: if (w_start) begin
        state_d  = START;
        cnt_d    = '0;
        dvsr_l_d = dvsr;
        par_l_d  = par_mode;
        armed_d  = 1'b0;
        s_d      = '0;
        n_d      = '0;
        sh_d     = '0;
        pbit_d   = 1'b0;
        pe_d     = 1'b0;
        fe_d     = 1'b0;
      end
      START: if (w_tick) begin
        if ((s_q == 5'd9) && w_vote) begin
          state_d = IDLE;
        end else if (s_q == 5'd15) begin
          state_d = DATA;
          s_d     = '0;
        end
      end
      DATA: if (w_tick) begin
        if (s_q == 5'd9) sh_d = {w_vote, sh_q[DBIT-1:1]};
        if (s_q == 5'd15) begin
          s_d = '0;
          if (n_q == c_NW'(DBIT - 1)) state_d = w_par_en ? PARITY : STOP;
          else                        n_d     = n_q + 1'b1;
        end
      end
      PARITY: if (w_tick) begin
        // par_l_q[1] set means odd parity: flips the expected bit
        if (s_q == 5'd9) begin
          pbit_d = w_vote;
          pe_d   = w_vote ^ (^sh_q) ^ par_l_q[1];
        end
        if (s_q == 5'd15) begin
          state_d = STOP;
          s_d     = '0;
        end
      end
      STOP: if (w_tick) begin
        if (s_q == 5'd9) fe_d = !w_vote;
        if (w_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    ovr_d   = ovr_q;
    if (valid_q && r_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (w_done) begin
      if (!valid_q || r_ready) begin
        valid_d = 1'b1;
        data_d  = sh_q;
        perr_d  = pe_q && !w_brk;
        ferr_d  = fe_q;
        brk_d   = w_brk;
        ovr_d   = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvsr_l_q <= '0;
      par_l_q  <= '0;
      armed_q  <= 1'b0;
      s_q      <= '0;
      n_q      <= '0;
      sh_q     <= '0;
      s7_q     <= 1'b0;
      s8_q     <= 1'b0;
      pbit_q   <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      meta_q   <= rx;
      rx_s_q   <= meta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvsr_l_q <= dvsr_l_d;
      par_l_q  <= par_l_d;
      armed_q  <= armed_d;
      s_q      <= s_d;
      n_q      <= n_d;
      sh_q     <= sh_d;
      s7_q     <= s7_d;
      s8_q     <= s8_d;
      pbit_q   <= pbit_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      brk_q    <= brk_d;
      ovr_q    <= ovr_d;
    end
  end

  assign r_data     = data_q;
  assign r_valid    = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_uart_rx_ext: directed frames against uart_rx_ext with hand-computed results.
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_uart_rx_ext;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dvsr;
  logic [1:0]  par_mode;
  logic        rx;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ready;
  logic        parity_err, frame_err, break_det, overrun, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_rx_ext #(.DBIT(8), .SB_TICK(16), .DVSR_BIT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .dvsr       (dvsr),
    .par_mode   (par_mode),
    .rx         (rx),
    .r_data     (r_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .overrun    (overrun),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Line bits LSB first, bit_clks clocks each; optional 1-clock inversion.
  task automatic send_line(input logic [15:0] bits, input int nbits, input int bit_clks,
                           input int g_idx, input int g_off);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < bit_clks; c++) begin
        rx = bits[i] ^ ((i == g_idx) && (c == g_off));
        @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  function automatic logic [15:0] mk8(input logic [7:0] d, input logic stop);
    return {6'd0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] mkp(input logic [7:0] d, input logic p);
    return {5'd0, 1'b1, p, d, 1'b0};
  endfunction

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!r_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 32'(r_valid), 32'd1);
  endtask

  task automatic accept(input string tag);
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    check({tag, "_drop"}, 32'(r_valid), 32'd0);
  endtask

  task automatic gap();
    repeat (40) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; rx = 1'b1; r_ready = 1'b0; dvsr = 16'd3; par_mode = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(r_valid), 32'd0);
    check("rst_data", 32'(r_data), 32'd0);
    check("rst_flags", 32'({parity_err, frame_err, break_det, overrun, busy}), 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // 8N1 0xA5 with exact completion latency
    send_line(mk8(8'hA5, 1'b1), 10, 64, -1, 0);
    check("t1_lat0", 32'(r_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("t1_lat2", 32'(r_valid), 32'd0);
    @(negedge clk);
    check("t1_lat3", 32'(r_valid), 32'd1);
    check("t1_data", 32'(r_data), 32'hA5);
    check("t1_flags", 32'({parity_err, frame_err, break_det, overrun, busy}), 32'd0);
    accept("t1");
    gap();

    // even parity
    par_mode = 2'b01;
    send_line(mkp(8'h81, 1'b0), 11, 64, -1, 0);
    wait_valid("t2a", 10);
    check("t2a_data", 32'(r_data), 32'h81);
    check("t2a_pe", 32'(parity_err), 32'd0);
    accept("t2a");
    gap();
    send_line(mkp(8'h81, 1'b1), 11, 64, -1, 0);
    wait_valid("t2b", 10);
    check("t2b_data", 32'(r_data), 32'h81);
    check("t2b_pe", 32'(parity_err), 32'd1);
    check("t2b_fe", 32'(frame_err), 32'd0);
    accept("t2b");
    par_mode = 2'b00;
    gap();

    // framing error
    send_line(mk8(8'h3C, 1'b0), 10, 64, -1, 0);
    wait_valid("t3", 10);
    check("t3_data", 32'(r_data), 32'h3C);
    check("t3_fe", 32'(frame_err), 32'd1);
    check("t3_brk", 32'(break_det), 32'd0);
    accept("t3");
    gap();

    // break: line held low, must not retrigger
    rx = 1'b0;
    repeat (704) @(negedge clk);
    check("t4_valid", 32'(r_valid), 32'd1);
    check("t4_data", 32'(r_data), 32'h00);
    check("t4_flags", 32'({parity_err, frame_err, break_det}), 32'b011);
    accept("t4");
    repeat (300) @(negedge clk);
    check("t4_noretrig", 32'({r_valid, busy}), 32'd0);
    rx = 1'b1;
    gap();

    // overrun
    send_line(mk8(8'h11, 1'b1), 10, 64, -1, 0);
    gap();
    send_line(mk8(8'h22, 1'b1), 10, 64, -1, 0);
    repeat (5) @(negedge clk);
    check("t5_valid", 32'(r_valid), 32'd1);
    check("t5_data", 32'(r_data), 32'h11);
    check("t5_ovr", 32'(overrun), 32'd1);
    accept("t5");
    check("t5_ovr_clr", 32'(overrun), 32'd0);
    gap();

    // false start of 4 ticks
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (700) @(negedge clk);
    check("t6_false", 32'({r_valid, busy}), 32'd0);

    // reset mid-DATA while a word is held
    send_line(mk8(8'h33, 1'b1), 10, 64, -1, 0);
    wait_valid("t6_hold", 10);
    gap();
    send_line(mk8(8'hFF, 1'b1), 4, 64, -1, 0);
    check("t6_busy_mid", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(r_valid), 32'd0);
    check("t6_rst_data", 32'(r_data), 32'd0);
    check("t6_rst_flags", 32'({parity_err, frame_err, break_det, overrun, busy}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    gap();
    send_line(mk8(8'h5A, 1'b1), 10, 64, -1, 0);
    wait_valid("t6_5a", 10);
    check("t6_5a_data", 32'(r_data), 32'h5A);
    check("t6_5a_flags", 32'({parity_err, frame_err, break_det, overrun}), 32'd0);
    accept("t6_5a");
    gap();

    // dvsr=0: spike on data bit 2 hits only the s=8 sample
    dvsr = 16'd0;
    send_line(mk8(8'h00, 1'b1), 10, 16, 3, 9);
    wait_valid("spike", 10);
    check("spike_data", 32'(r_data), 32'h00);
    accept("spike");
    dvsr = 16'd3;
    gap();

    // divisor changed mid-frame
    send_line(mk8(8'hC3, 1'b1), 5, 64, -1, 0);
    dvsr = 16'd0;
    send_line(mk8(8'hC3, 1'b1) >> 5, 5, 64, -1, 0);
    wait_valid("dvchg", 10);
    check("dvchg_data", 32'(r_data), 32'hC3);
    check("dvchg_fe", 32'(frame_err), 32'd0);
    accept("dvchg");
    dvsr = 16'd3;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
